unidade_controle_rodadas: RTL

Control unit for the sequence-memory game, generalised to rounds with a play timeout. Each round r (0-based) requires the player to reproduce positions 0..r of the stored sequence. The game is won after round N_RODADAS-1. The block owns the position and round counters and the timeout counter. It drives the memory address, the play register and the comparator handshake of the datapath.

---
 rtl/unidade_controle_rodadas.sv | 133 +++++++++++++
 1 files changed

// File: rtl/unidade_controle_rodadas.sv
// Round-based control unit for the sequence-memory game.
// Owns position, round and play-timeout counters; outputs are registered Moore decodes.
module unidade_controle_rodadas #(
  parameter int N_RODADAS      = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int TIMEOUT_W      = 13,
  parameter int TIMEOUT_EN     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic              igual,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic              zeraR,
  output logic              registraR,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    inicial        = 4'h0,
    inicializa     = 4'h1,
    inicio_rodada  = 4'h2,
    espera         = 4'h3,
    registra       = 4'h4,
    compara        = 4'h5,
    proxima        = 4'h6,
    proxima_rodada = 4'h7,
    final_acerto   = 4'hA,
    final_timeout  = 4'hD,
    final_erro     = 4'hE
  } estado_t;

  estado_t              estado, estado_prox;
  logic [ADDR_W-1:0]    endereco_prox, rodada_prox;
  logic [TIMEOUT_W-1:0] contagem, contagem_prox;

  function automatic logic [3:0] codigo(input estado_t e);
    case (e)
      inicial, inicializa, inicio_rodada, espera, registra, compara,
      proxima, proxima_rodada, final_acerto, final_timeout, final_erro: codigo = e;
      default: codigo = 4'h8;
    endcase
  endfunction

  always_comb begin
    estado_prox   = estado;
    endereco_prox = endereco;
    rodada_prox   = rodada;
    contagem_prox = contagem;
    case (estado)
      inicial:       if (iniciar) estado_prox = inicializa;
      inicializa: begin
        rodada_prox = '0;
        estado_prox = inicio_rodada;
      end
      inicio_rodada: begin
        endereco_prox = '0;
        contagem_prox = '0;
        estado_prox   = espera;
      end
      espera: begin
        // a play in the expiry cycle still wins over the timeout
        if (jogada)
          estado_prox = registra;
        else if ((TIMEOUT_EN != 0) && (contagem == TIMEOUT_W'(TIMEOUT_CICLOS - 1)))
          estado_prox = final_timeout;
        else
          contagem_prox = contagem + TIMEOUT_W'(1);
      end
      registra:      estado_prox = compara;
      compara: begin
        if (!igual)
          estado_prox = final_erro;
        else if (endereco != rodada)
          estado_prox = proxima;
        else if (rodada == ADDR_W'(N_RODADAS - 1))
          estado_prox = final_acerto;
        else
          estado_prox = proxima_rodada;
      end
      proxima: begin
        endereco_prox = endereco + ADDR_W'(1);
        contagem_prox = '0;
        estado_prox   = espera;
      end
      proxima_rodada: begin
        rodada_prox = rodada + ADDR_W'(1);
        estado_prox = inicio_rodada;
      end
      final_acerto, final_erro, final_timeout:
        if (iniciar) estado_prox = inicializa;
      default:       estado_prox = inicial;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= inicial;
      endereco  <= '0;
      rodada    <= '0;
      contagem  <= '0;
      zeraR     <= 1'b1;
      registraR <= 1'b0;
      acertou   <= 1'b0;
      errou     <= 1'b0;
      timeout   <= 1'b0;
      pronto    <= 1'b0;
      db_estado <= 4'h0;
    end else begin
      estado    <= estado_prox;
      endereco  <= endereco_prox;
      rodada    <= rodada_prox;
      contagem  <= contagem_prox;
      zeraR     <= (estado_prox == inicial) || (estado_prox == inicializa);
      registraR <= (estado_prox == registra);
      acertou   <= (estado_prox == final_acerto);
      errou     <= (estado_prox == final_erro);
      timeout   <= (estado_prox == final_timeout);
      pronto    <= (estado_prox == final_acerto) || (estado_prox == final_erro) ||
                   (estado_prox == final_timeout);
      db_estado <= codigo(estado_prox);
    end
  end

endmodule
